mem_port_arbiter: RTL and testbench

- Shares the single-port unified RAM between the CPU instruction-fetch port and the data load/store port.
- One transaction is outstanding at a time; read latency is fixed.
- Data accesses take priority. An optional starvation guard bounds how long a fetch can wait.
- Sits between the CPU and the RAM instance inside top; the fetch result feeds the instruction read bus.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store; data has priority.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after MAX_DATA_BURST data grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iReq,
    input  logic [ADDR_WIDTH-1:0]   iAddr,
    output logic                    iReady,
    output logic                    iValid,
    output logic [DATA_WIDTH-1:0]   iRData,
    input  logic                    dReq,
    input  logic                    dWe,
    input  logic [ADDR_WIDTH-1:0]   dAddr,
    input  logic [DATA_WIDTH-1:0]   dWData,
    input  logic [DATA_WIDTH/8-1:0] dMask,
    output logic                    dReady,
    output logic                    dValid,
    output logic [DATA_WIDTH-1:0]   dRData,
    output logic                    memEn,
    output logic                    memWe,
    output logic [ADDR_WIDTH-1:0]   memAddr,
    output logic [DATA_WIDTH-1:0]   memWData,
    output logic [DATA_WIDTH/8-1:0] memMask,
    input  logic [DATA_WIDTH-1:0]   memRData,
    output logic                    busy
);

    localparam logic [2:0] RL = 3'(READ_LATENCY);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       done, arb, grant_i, grant_d, force_i;

    // Outputs are gated by reset so nothing leaks while the state is being cleared.
    assign done = !reset && (state_q == RD_WAIT) && (cnt_q == RL);
    assign arb  = !reset && ((state_q == IDLE) || done);

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned BW = $clog2(MAX_DATA_BURST + 2);

    logic [BW-1:0] burst_q, burst_d;

    assign force_i = iReq && (burst_q == BW'(MAX_DATA_BURST));

    always_comb begin
        burst_d = burst_q;
        if (arb) begin
            if (grant_i || !iReq) begin
                burst_d = '0;
            end else if (grant_d && (burst_q != BW'(MAX_DATA_BURST))) begin
                burst_d = burst_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        if ((state_q == RD_WAIT) && !done) begin
            cnt_d = cnt_q + 3'd1;
        end
        if (arb) begin
            if (grant_i || (grant_d && !dWe)) begin
                state_d = RD_WAIT;
                cnt_d   = 3'd1;
                owner_d = grant_d;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
                owner_d = 1'b0;
            end
        end
    end

    always_comb begin
        grant_d  = arb && dReq && !force_i;
        grant_i  = arb && iReq && !grant_d;
        iReady   = grant_i;
        dReady   = grant_d;
        memEn    = grant_i || grant_d;
        memWe    = grant_d && dWe;
        memAddr  = '0;
        memWData = '0;
        memMask  = '0;
        if (grant_d) begin
            memAddr  = dAddr;
            memWData = dWData;
            memMask  = dMask;
        end else if (grant_i) begin
            memAddr  = iAddr;
            memMask  = '1;
        end
        iValid = done && !owner_q;
        dValid = done && owner_q;
        iRData = iValid ? memRData : '0;
        dRData = dValid ? memRData : '0;
        busy   = !reset && (state_q == RD_WAIT);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-timeline model, plus directed literal checks.
module tb_mem_port_arbiter;

    localparam int RL   = 3;
    localparam int MAXB = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk, rst;
    // instance A: READ_LATENCY=3, randomized + model
    logic        iReq, iReady, iValid, dReq, dWe, dReady, dValid, memEn, memWe, busy;
    logic [31:0] iAddr, iRData, dAddr, dWData, dRData, memAddr, memWData, memRData;
    logic [3:0]  dMask, memMask;
    // instance B: READ_LATENCY=1, directed only
    logic        b_iReq, b_iReady, b_iValid, b_dReq, b_dWe, b_dReady, b_dValid, b_memEn, b_memWe, b_busy;
    logic [31:0] b_iAddr, b_iRData, b_dAddr, b_dWData, b_dRData, b_memAddr, b_memWData, b_memRData;
    logic [3:0]  b_dMask, b_memMask;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(RL), .MAX_DATA_BURST(MAXB)) u_dut (
        .clk(clk), .reset(rst),
        .iReq(iReq), .iAddr(iAddr), .iReady(iReady), .iValid(iValid), .iRData(iRData),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData), .dMask(dMask),
        .dReady(dReady), .dValid(dValid), .dRData(dRData),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWData(memWData), .memMask(memMask),
        .memRData(memRData), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1), .MAX_DATA_BURST(MAXB)) u_dut1 (
        .clk(clk), .reset(rst),
        .iReq(b_iReq), .iAddr(b_iAddr), .iReady(b_iReady), .iValid(b_iValid), .iRData(b_iRData),
        .dReq(b_dReq), .dWe(b_dWe), .dAddr(b_dAddr), .dWData(b_dWData), .dMask(b_dMask),
        .dReady(b_dReady), .dValid(b_dValid), .dRData(b_dRData),
        .memEn(b_memEn), .memWe(b_memWe), .memAddr(b_memAddr), .memWData(b_memWData), .memMask(b_memMask),
        .memRData(b_memRData), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM environments
    logic [31:0] ram  [64];
    logic [31:0] ram1 [64];
    logic [31:0] pipe [RL];
    bit ram_init = 0, ram1_init = 0;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'hC0DE0000 | 32'(i);
            ram_init <= 1'b1;
        end else if (memEn && memWe) begin
            for (int b = 0; b < 4; b++)
                if (memMask[b]) ram[memAddr[7:2]][8*b +: 8] <= memWData[8*b +: 8];
        end
        pipe[0] <= (memEn && !memWe) ? ram[memAddr[7:2]] : 32'hBAD0BAD0;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign memRData = pipe[RL-1];

    always @(posedge clk) begin
        if (!ram1_init) begin
            for (int i = 0; i < 64; i++) ram1[i] <= (i == 4) ? 32'h00000013 : (32'h11110000 | 32'(i));
            ram1_init <= 1'b1;
        end else if (b_memEn && b_memWe) begin
            for (int b = 0; b < 4; b++)
                if (b_memMask[b]) ram1[b_memAddr[7:2]][8*b +: 8] <= b_memWData[8*b +: 8];
        end
        b_memRData <= (b_memEn && !b_memWe) ? ram1[b_memAddr[7:2]] : 32'hBAD1BAD1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
        end
    endtask

    // Behavioural model: a timeline of when the port is free plus a queue of pending read results.
    typedef struct {int t; bit d; logic [31:0] data;} rd_t;
    rd_t         rq[$];
    logic [31:0] shadow [64];
    bit          sh_init = 0;
    int          free_at = 0, lri = -100, burst = 0;
    bit          m_arb, m_frc, m_gi, m_gd, m_iv, m_dv, m_en, m_we, m_busy;
    logic [31:0] m_addr, m_wd, m_rd;
    logic [3:0]  m_mask;

    always @(negedge clk) begin
        if (!sh_init) begin
            for (int i = 0; i < 64; i++) shadow[i] = 32'hC0DE0000 | 32'(i);
            sh_init = 1;
        end
        m_gi = 0; m_gd = 0; m_iv = 0; m_dv = 0; m_en = 0; m_we = 0; m_busy = 0;
        m_addr = '0; m_wd = '0; m_rd = '0; m_mask = '0; m_arb = 0;
        if (rst) begin
            rq.delete();
            free_at = cyc_n + 1;
            lri = -100;
            burst = 0;
        end else begin
            m_arb = (cyc_n >= free_at);
            m_frc = GUARD && (burst == MAXB) && iReq;
            m_gd  = m_arb && dReq && !m_frc;
            m_gi  = m_arb && iReq && !m_gd;
            m_en  = m_gi || m_gd;
            m_we  = m_gd && dWe;
            m_addr = m_gd ? dAddr : (m_gi ? iAddr : 32'h0);
            m_mask = m_gd ? dMask : (m_gi ? 4'hF : 4'h0);
            m_wd   = m_gd ? dWData : 32'h0;
            if (rq.size() > 0 && rq[0].t == cyc_n) begin
                m_iv = !rq[0].d;
                m_dv = rq[0].d;
                m_rd = rq[0].data;
                void'(rq.pop_front());
            end
            m_busy = (cyc_n > lri) && (cyc_n <= lri + RL);
        end
        chk("iReady", iReady, m_gi);
        chk("dReady", dReady, m_gd);
        chk("iValid", iValid, m_iv);
        chk("dValid", dValid, m_dv);
        chk("iRData", iRData, m_iv ? m_rd : 32'h0);
        chk("dRData", dRData, m_dv ? m_rd : 32'h0);
        chk("memEn", memEn, m_en);
        chk("memWe", memWe, m_we);
        chk("memAddr", memAddr, m_addr);
        chk("memWData", memWData, m_wd);
        chk("memMask", memMask, m_mask);
        chk("busy", busy, m_busy);
        if (m_en) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_mask[b]) shadow[m_addr[7:2]][8*b +: 8] = m_wd[8*b +: 8];
                free_at = cyc_n + 1;
            end else begin
                rq.push_back('{cyc_n + RL, m_gd, shadow[m_addr[7:2]]});
                free_at = cyc_n + RL;
                lri = cyc_n;
            end
        end
        if (m_arb) begin
            if (m_gi || !iReq) burst = 0;
            else if (m_gd && burst < MAXB) burst++;
        end
        cyc_n++;
    end

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic ir, dr, got_i;
    int   n_d, first_i;
    int   prob[3] = '{25, 60, 90};

    initial begin
        rst = 1; iReq = 0; iAddr = 0; dReq = 0; dWe = 0; dAddr = 0; dWData = 0; dMask = 0;
        b_iReq = 0; b_iAddr = 0; b_dReq = 0; b_dWe = 0; b_dAddr = 0; b_dWData = 0; b_dMask = 0;
        nxt(); nxt();
        // requests during reset must be ignored
        dReq = 1; dAddr = 32'h40; b_iReq = 1; b_iAddr = 32'h10;
        smp();
        chk("rst_dReady", dReady, 0); chk("rst_memEn", memEn, 0);
        chk("rst_b_iReady", b_iReady, 0); chk("rst_busy", busy, 0);
        nxt(); rst = 0; dReq = 0; b_iReq = 0;
        nxt();

        // RL=1 fetch
        b_iReq = 1; b_iAddr = 32'h10;
        smp();
        chk("t1_iReady", b_iReady, 1); chk("t1_memEn", b_memEn, 1);
        chk("t1_memAddr", b_memAddr, 32'h10); chk("t1_memWe", b_memWe, 0);
        chk("t1_memMask", b_memMask, 4'hF); chk("t1_busy_c0", b_busy, 0);
        nxt(); b_iReq = 0;
        smp();
        chk("t1_iValid", b_iValid, 1); chk("t1_iRData", b_iRData, 32'h00000013); chk("t1_busy_c1", b_busy, 1);
        nxt();
        smp();
        chk("t1_busy_c2", b_busy, 0); chk("t1_iValid_c2", b_iValid, 0); chk("t1_iRData_c2", b_iRData, 0);
        nxt();

        // RL=1 simultaneous requests: masked write wins
        b_iReq = 1; b_iAddr = 32'h14;
        b_dReq = 1; b_dWe = 1; b_dAddr = 32'h20; b_dWData = 32'hDEADBEEF; b_dMask = 4'b0011;
        smp();
        chk("t2_dReady", b_dReady, 1); chk("t2_iReady", b_iReady, 0); chk("t2_memWe", b_memWe, 1);
        chk("t2_memMask", b_memMask, 4'b0011); chk("t2_memWData", b_memWData, 32'hDEADBEEF);
        nxt(); b_dReq = 0;
        smp();
        chk("t2_iReady_c1", b_iReady, 1); chk("t2_memAddr_c1", b_memAddr, 32'h14); chk("t2_dValid_c1", b_dValid, 0);
        nxt(); b_iAddr = 32'h10;
        smp();
        // back-to-back fetch at RL=1: completion and next issue in one cycle
        chk("t2_iValid_c2", b_iValid, 1); chk("t2_iRData_c2", b_iRData, 32'h11110005);
        chk("t2_iReady_c2", b_iReady, 1); chk("t2_dValid_c2", b_dValid, 0);
        nxt(); b_iReq = 0; b_dReq = 1; b_dWe = 0; b_dAddr = 32'h20;
        smp();
        chk("t2_iRData_c3", b_iRData, 32'h00000013); chk("t2_ld_dReady", b_dReady, 1);
        nxt(); b_dReq = 0;
        smp();
        chk("t2_ld_dValid", b_dValid, 1); chk("t2_ld_dRData", b_dRData, 32'h1111BEEF);
        nxt();

        // RL=3 load then fetch
        dReq = 1; dWe = 0; dAddr = 32'h40; dMask = 4'hF;
        smp();
        chk("tA_dReady", dReady, 1); chk("tA_memAddr", memAddr, 32'h40);
        nxt(); dReq = 0; iReq = 1; iAddr = 32'h80;
        smp(); chk("tA_iReady_c1", iReady, 0); chk("tA_busy_c1", busy, 1);
        nxt();
        smp(); chk("tA_iReady_c2", iReady, 0);
        nxt();
        smp();
        chk("tA_dValid_c3", dValid, 1); chk("tA_dRData_c3", dRData, 32'hC0DE0010);
        chk("tA_iReady_c3", iReady, 1); chk("tA_memAddr_c3", memAddr, 32'h80);
        nxt(); iReq = 0;
        smp(); chk("tA_iValid_c4", iValid, 0);
        nxt();
        smp(); chk("tA_iValid_c5", iValid, 0);
        nxt();
        smp(); chk("tA_iValid_c6", iValid, 1); chk("tA_iRData_c6", iRData, 32'hC0DE0020);
        nxt();
        smp(); chk("tA_busy_c7", busy, 0);
        nxt();

        // RL=3 reset in cycle 1 of a load
        dReq = 1; dWe = 0; dAddr = 32'h44;
        smp(); chk("tB_dReady", dReady, 1);
        nxt(); dReq = 0; rst = 1;
        smp(); chk("tB_busy_rst", busy, 0); chk("tB_memEn_rst", memEn, 0); chk("tB_dValid_rst", dValid, 0);
        nxt(); rst = 0;
        for (int k = 2; k < 8; k++) begin
            smp(); chk("tB_no_dValid", dValid, 0); chk("tB_no_busy", busy, 0);
            nxt();
        end
        iReq = 1; iAddr = 32'h48;
        smp(); chk("tB_fetch_iReady", iReady, 1);
        nxt(); iReq = 0;
        smp(); nxt();
        smp(); nxt();
        smp(); chk("tB_fetch_iValid", iValid, 1); chk("tB_fetch_iRData", iRData, 32'hC0DE0012);
        nxt();

        // fetch under continuous write pressure
        iReq = 1; iAddr = 32'h0C; dReq = 1; dWe = 1; dAddr = 32'hC0; dWData = $urandom; dMask = 4'hF;
        n_d = 0; got_i = 0; first_i = -1;
        for (int k = 0; k < 12; k++) begin
            smp();
            ir = iReady; dr = dReady;
            if (ir && !got_i) begin got_i = 1; first_i = k; end
            if (dr && !got_i) n_d++;
            nxt();
            if (ir) iReq = 0;
            if (dr) begin dAddr = 32'hC0 + (32'($urandom_range(0, 15)) << 2); dWData = $urandom; end
        end
        dReq = 0;
`ifdef ARB_STARVE_GUARD_EN
        chk("starve_data_grants", n_d, MAXB);
        chk("starve_first_fetch", first_i, MAXB);
`else
        chk("starve_data_grants", n_d, 12);
        chk("starve_no_fetch", got_i, 0);
        smp(); chk("starve_release_iReady", iReady, 1);
        nxt(); iReq = 0;
`endif
        repeat (5) nxt();

        // randomized traffic
        foreach (prob[p]) begin
            repeat (1000) begin
                smp();
                ir = iReady; dr = dReady;
                nxt();
                if (rst) begin
                    rst = 0;
                end else if ($urandom_range(0, 299) == 0) begin
                    rst = 1; iReq = 0; dReq = 0;
                end
                if (!rst) begin
                    if (iReq && !ir && $urandom_range(0, 31) == 0) begin
                        iReq = 0;
                    end else if (!iReq || ir) begin
                        iReq  = ($urandom_range(0, 99) < prob[p]);
                        iAddr = 32'($urandom_range(0, 63)) << 2;
                    end
                    if (dReq && !dr && $urandom_range(0, 31) == 0) begin
                        dReq = 0;
                    end else if (!dReq || dr) begin
                        dReq   = ($urandom_range(0, 99) < prob[p]);
                        dWe    = $urandom_range(0, 1);
                        dAddr  = 32'($urandom_range(0, 63)) << 2;
                        dWData = $urandom;
                        dMask  = 4'($urandom_range(0, 15));
                    end
                end
            end
        end
        iReq = 0; dReq = 0; rst = 0;
        repeat (6) nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
